pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. It watches stage state each cycle and drives the stall and bubble controls of the F, D, E, M and W pipeline registers, including the fetch register that holds the predicted PC. It handles load-use, ret and branch-mispredict hazards, and exception drain and halt. It also keeps saturating performance counters. It sits beside the datapath; every pipeline register takes its stall/bubble input from this block.

---
 rtl/y86_pkg.sv | 33 +++
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

  // Instruction codes the control unit cares about.
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register id meaning "no register".
  localparam logic [3:0] RNONE   = 4'hF;

  // Pipeline status codes.
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  // True for any status that stops the core (halt, bad address, bad insn).
  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-state inputs and stall/bubble/counter outputs between datapath and pipe_ctrl.
// Latency: wires only.
// Backpressure: none; master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // Stage state observed by the control unit
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       E_dstM;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic             e_Cnd;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;
  // Pipeline register controls
  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  // Status and performance counters
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
    input  halted, cycle_cnt, stall_cnt, mispred_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
    output halted, cycle_cnt, stall_cnt, mispred_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps. Ports: clk, reset, inc, count.
// Latency: increment visible one cycle after inc.
// Backpressure: none.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble per stage, exception drain/halt FSM, perf counters.
// Latency: controls combinational (0 cycles); FSM and counters update on the next clk edge.
// Backpressure: none; F_stall/D_stall hold upstream registers. Ports: clk, reset, bus (slave).
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);

  pipe_state_t state, state_nxt;

  logic load_use, ret_hz, mispred, exc_m, exc_w;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;

  // Hazard detection
  assign load_use = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
                    (bus.E_dstM != RNONE) &&
                    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign ret_hz   = (bus.D_icode == IRET) || (bus.E_icode == IRET) || (bus.M_icode == IRET);
  assign mispred  = (bus.E_icode == IJXX) && !bus.e_Cnd;
  assign exc_m    = is_exc(bus.m_stat);
  assign exc_w    = is_exc(bus.W_stat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    m_bubble  = 1'b0;
    w_stall   = 1'b0;
    set_cc    = 1'b0;

    case (state)
      // exc_w wins over exc_m so a simultaneous pair goes straight to HALTED
      RUN: begin
        if (exc_w) begin
          state_nxt = HALTED;
        end else if (exc_m) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (exc_w) begin
          state_nxt = HALTED;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase

    if (state == HALTED) begin
      // Freeze everything: hold F/D/W and keep M empty.
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      m_bubble = 1'b1;
      w_stall  = 1'b1;
    end else begin
      f_stall  = load_use | ret_hz;
      d_stall  = load_use;
      // A load-use stall must keep D intact, so it suppresses the ret bubble.
      d_bubble = mispred | (ret_hz & !load_use);
      e_bubble = mispred | load_use;
      m_bubble = exc_m | exc_w;
      w_stall  = exc_w;
      // No CC update once an excepting instruction is ahead of E.
      set_cc   = (bus.E_icode == IOPQ) & !exc_m & !exc_w;
    end
  end

  assign bus.F_stall  = f_stall;
  assign bus.D_stall  = d_stall;
  assign bus.D_bubble = d_bubble;
  assign bus.E_bubble = e_bubble;
  assign bus.M_bubble = m_bubble;
  assign bus.W_stall  = w_stall;
  assign bus.set_cc   = set_cc;
  assign bus.halted   = (state == HALTED);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state != HALTED),
    .count (bus.cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == RUN) && f_stall),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == RUN) && mispred),
    .count (bus.mispred_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/exception steps then random stimulus.
// Latency: checks controls #1 after inputs change and counters #1 after each rising edge.
// Backpressure: n/a.
module tb_pipe_ctrl;
  import y86_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [3:0] D_icode = 4'h1;
  logic [3:0] E_icode = 4'h1;
  logic [3:0] M_icode = 4'h1;
  logic [3:0] E_dstM  = 4'hF;
  logic [3:0] d_srcA  = 4'hF;
  logic [3:0] d_srcB  = 4'hF;
  logic       e_Cnd   = 1'b1;
  logic [2:0] m_stat  = 3'd1;
  logic [2:0] W_stat  = 3'd1;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted; counts are unbounded.
  int     m_mode = 0;
  longint m_cyc  = 0;
  longint m_stl  = 0;
  longint m_mis  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus32 ();
  pipe_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.D_icode = D_icode;  assign bus4.D_icode = D_icode;
  assign bus32.E_icode = E_icode;  assign bus4.E_icode = E_icode;
  assign bus32.M_icode = M_icode;  assign bus4.M_icode = M_icode;
  assign bus32.E_dstM  = E_dstM;   assign bus4.E_dstM  = E_dstM;
  assign bus32.d_srcA  = d_srcA;   assign bus4.d_srcA  = d_srcA;
  assign bus32.d_srcB  = d_srcB;   assign bus4.d_srcB  = d_srcB;
  assign bus32.e_Cnd   = e_Cnd;    assign bus4.e_Cnd   = e_Cnd;
  assign bus32.m_stat  = m_stat;   assign bus4.m_stat  = m_stat;
  assign bus32.W_stat  = W_stat;   assign bus4.W_stat  = W_stat;

  pipe_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus32.slave));
  pipe_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? 32'(lim) : 32'(v);
  endfunction

  function automatic bit exc(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  // Hazard terms straight from the hazard rules.
  function automatic bit f_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction
  function automatic bit f_rh();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction
  function automatic bit f_mp();
    return (E_icode == 4'h7) && !e_Cnd;
  endfunction

  task automatic check_comb();
    bit lu, rh, mp, em, ew;
    lu = f_lu(); rh = f_rh(); mp = f_mp(); em = exc(m_stat); ew = exc(W_stat);
    if (m_mode == 2) begin
      check("F_stall",  32'(bus32.F_stall),  32'd1);
      check("D_stall",  32'(bus32.D_stall),  32'd1);
      check("D_bubble", 32'(bus32.D_bubble), 32'd0);
      check("E_bubble", 32'(bus32.E_bubble), 32'd0);
      check("M_bubble", 32'(bus32.M_bubble), 32'd1);
      check("W_stall",  32'(bus32.W_stall),  32'd1);
      check("set_cc",   32'(bus32.set_cc),   32'd0);
    end else begin
      check("F_stall",  32'(bus32.F_stall),  32'(lu || rh));
      check("D_stall",  32'(bus32.D_stall),  32'(lu));
      check("D_bubble", 32'(bus32.D_bubble), 32'(mp || (rh && !lu)));
      check("E_bubble", 32'(bus32.E_bubble), 32'(mp || lu));
      check("M_bubble", 32'(bus32.M_bubble), 32'(em || ew));
      check("W_stall",  32'(bus32.W_stall),  32'(ew));
      check("set_cc",   32'(bus32.set_cc),   32'((E_icode == 4'h6) && !em && !ew));
    end
  endtask

  task automatic check_seq();
    check("halted",        32'(bus32.halted),  32'(m_mode == 2));
    check("halted4",       32'(bus4.halted),   32'(m_mode == 2));
    check("cycle_cnt",     bus32.cycle_cnt,    sat(m_cyc, 32));
    check("stall_cnt",     bus32.stall_cnt,    sat(m_stl, 32));
    check("mispred_cnt",   bus32.mispred_cnt,  sat(m_mis, 32));
    check("cycle_cnt4",    32'(bus4.cycle_cnt),   sat(m_cyc, 4));
    check("stall_cnt4",    32'(bus4.stall_cnt),   sat(m_stl, 4));
    check("mispred_cnt4",  32'(bus4.mispred_cnt), sat(m_mis, 4));
  endtask

  // One clock: check controls, take the edge, advance the model, check state/counters.
  task automatic tick();
    bit em, ew;
    #1;
    check_comb();
    @(posedge clk);
    em = exc(m_stat); ew = exc(W_stat);
    if (m_mode != 2) m_cyc++;
    if (m_mode == 0 && (f_lu() || f_rh())) m_stl++;
    if (m_mode == 0 && f_mp()) m_mis++;
    if (m_mode == 0) m_mode = ew ? 2 : (em ? 1 : 0);
    else if (m_mode == 1 && ew) m_mode = 2;
    #1;
    check_seq();
  endtask

  // Reset asserted between edges; its effect must be visible without a clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    m_mode = 0; m_cyc = 0; m_stl = 0; m_mis = 0;
    check_seq();
    check_comb();
    reset = 1'b0;
  endtask

  task automatic set_in(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                        input logic [3:0] dstm, input logic [3:0] sa, input logic [3:0] sb,
                        input logic cnd, input logic [2:0] ms, input logic [2:0] ws);
    D_icode = d; E_icode = e; M_icode = m; E_dstM = dstm;
    d_srcA = sa; d_srcB = sb; e_Cnd = cnd; m_stat = ms; W_stat = ws;
  endtask

  task automatic idle();
    set_in(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
  endtask

  initial begin
    logic [3:0] icodes [12];
    for (int i = 0; i < 12; i++) icodes[i] = 4'(i);

    // Reset state
    #2;
    check_seq();
    check_comb();
    reset = 1'b0;

    // Load-use: mrmovq into %rbx while D reads %rbx
    idle();
    set_in(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 3'd1, 3'd1);
    tick();
    // popq with RNONE dst is not a hazard
    set_in(4'h1, 4'hB, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    tick();

    // ret in M, then D, E across three cycles
    async_reset();
    idle(); M_icode = 4'h9; tick();
    idle(); D_icode = 4'h9; tick();
    idle(); E_icode = 4'h9; tick();

    // Load-use and ret together: stall wins
    set_in(4'h9, 4'h5, 4'h1, 4'h2, 4'h7, 4'h2, 1'b1, 3'd1, 3'd1);
    tick();

    // Mispredicted jump, then mispred with ret in D
    idle(); E_icode = 4'h7; e_Cnd = 1'b0; tick();
    D_icode = 4'h9; tick();
    // Taken jump is not a mispredict
    idle(); E_icode = 4'h7; e_Cnd = 1'b1; tick();

    // OPq with exception leaving M -> drain, then W excepts -> halted
    idle(); E_icode = 4'h6; tick();
    m_stat = 3'd3; tick();
    idle(); E_icode = 4'h6; W_stat = 3'd3; tick();
    idle(); E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    for (int i = 0; i < 3; i++) tick();

    // Reset while halted
    async_reset();
    idle(); tick();

    // Simultaneous exc_m and exc_w go straight to halted
    idle(); m_stat = 3'd2; W_stat = 3'd4; tick();
    idle(); tick();
    async_reset();

    // Saturation of the 4-bit counters under a long stall
    idle(); E_icode = 4'h5; E_dstM = 4'h1; d_srcB = 4'h1;
    for (int i = 0; i < 20; i++) tick();
    async_reset();

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      int r;
      D_icode = icodes[$urandom_range(0, 11)];
      E_icode = icodes[$urandom_range(0, 11)];
      M_icode = icodes[$urandom_range(0, 11)];
      r = $urandom_range(0, 4); E_dstM = (r == 4) ? 4'hF : 4'(r);
      r = $urandom_range(0, 4); d_srcA = (r == 4) ? 4'hF : 4'(r);
      r = $urandom_range(0, 4); d_srcB = (r == 4) ? 4'hF : 4'(r);
      e_Cnd  = 1'($urandom_range(0, 1));
      m_stat = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      tick();
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
